// File: rtl/ex_iter_pkg.sv
// rtl/ex_iter_pkg.sv - shared opcodes, result selects and divider state encodings
package ex_iter_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [ALUOP_W-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [ALUOP_W-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [ALUOP_W-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [ALUOP_W-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;
  localparam logic [ALUSEL_W-1:0] EXE_RES_MUL   = 3'b101;
  localparam logic [ALUSEL_W-1:0] EXE_RES_DIV   = 3'b110;

  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        RstEnable = 1'b1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/ex_iter_div.sv
// rtl/ex_iter_div.sv - iterative radix-2 restoring divider (module div_iter)
// Optional div_zero_o port under EX_DIV_ZERO_TRAP_EN.
module div_iter
  import ex_iter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
`ifdef EX_DIV_ZERO_TRAP_EN
  ,
  output logic              div_zero_o
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] quo_q, quo_d, rem_q, rem_d, div_q, div_d;
  logic              q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   partial;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;

    a_neg   = signed_op_i & dividend_i[DATA_W-1];
    b_neg   = signed_op_i & divisor_i[DATA_W-1];
    a_mag   = a_neg ? -dividend_i : dividend_i;
    b_mag   = b_neg ? -divisor_i : divisor_i;
    partial = {rem_q, quo_q[DATA_W-1]};

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !abort_i) begin
          busy_o  = 1'b1;
          count_d = '0;
          div_d   = b_mag;
          r_neg_d = a_neg;
          if (divisor_i == '0) begin
            // Zero divisor: all-ones quotient, remainder resigns back to the dividend.
            quo_d   = '1;
            rem_d   = a_mag;
            q_neg_d = 1'b0;
            state_d = DIV_DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            state_d = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (abort_i) begin
          state_d = DIV_IDLE;
        end else begin
          busy_o = 1'b1;
          if (partial >= {1'b0, div_q}) begin
            rem_d = partial[DATA_W-1:0] - div_q;
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = partial[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(DATA_W - 1)) state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done_o  = !abort_i;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign quotient_o  = q_neg_q ? -quo_q : quo_q;
  assign remainder_o = r_neg_q ? -rem_q : rem_q;

`ifdef EX_DIV_ZERO_TRAP_EN
  assign div_zero_o = (state_q == DIV_DONE) && (div_q == '0);
`endif

endmodule

// File: rtl/ex_iter.sv
// rtl/ex_iter.sv - execute stage: single-cycle ALU/multiply plus iterative divide
// EX_DIV_ZERO_TRAP_EN adds div_zero_o and suppresses the HI/LO write on divide by zero.
module ex_iter
  import ex_iter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  flush_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o,
  output logic                  valid_o
`ifdef EX_DIV_ZERO_TRAP_EN
  ,
  output logic                  div_zero_o
`endif
);

  logic                  active, is_mul, is_div;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_W-1:0]     logic_res, shift_res, arith_res, gpr_res;
  logic [2*DATA_W-1:0]   mul_a, mul_b, product;
  logic                  div_busy, div_done;
  logic [DATA_W-1:0]     div_quo, div_rem;
`ifdef EX_DIV_ZERO_TRAP_EN
  logic                  div_zero;
`endif

  assign active = valid_i & !flush_i;
  assign shamt  = reg2_i[SHAMT_W-1:0];
  assign is_mul = (alusel_i == EXE_RES_MUL) && (aluop_i == EXE_MULT_OP || aluop_i == EXE_MULTU_OP);
  assign is_div = (alusel_i == EXE_RES_DIV) && (aluop_i == EXE_DIV_OP || aluop_i == EXE_DIVU_OP);

  // Sign- or zero-extend to 2*DATA_W so one multiplier serves MULT and MULTU.
  assign mul_a   = (aluop_i == EXE_MULT_OP) ? {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} : {{DATA_W{1'b0}}, reg1_i};
  assign mul_b   = (aluop_i == EXE_MULT_OP) ? {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i} : {{DATA_W{1'b0}}, reg2_i};
  assign product = mul_a * mul_b;

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    gpr_res   = '0;
    case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg1_i << shamt;
      EXE_SRL_OP:  shift_res = reg1_i >> shamt;
      EXE_SRA_OP:  shift_res = DATA_W'($signed(reg1_i) >>> shamt);
      EXE_ADD_OP:  arith_res = reg1_i + reg2_i;
      EXE_SUB_OP:  arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      default: ;
    endcase
    case (alusel_i)
      EXE_RES_LOGIC: gpr_res = logic_res;
      EXE_RES_SHIFT: gpr_res = shift_res;
      EXE_RES_ARITH: gpr_res = arith_res;
      default:       gpr_res = '0;
    endcase
  end

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (valid_i & is_div & !flush_i),
    .signed_op_i (aluop_i == EXE_DIV_OP),
    .dividend_i  (reg1_i),
    .divisor_i   (reg2_i),
    .abort_i     (flush_i),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
`ifdef EX_DIV_ZERO_TRAP_EN
    ,
    .div_zero_o  (div_zero)
`endif
  );

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = 1'b0;
    wdata_o    = DATA_W'(ZeroWord);
    whilo_o    = 1'b0;
    hi_o       = DATA_W'(ZeroWord);
    lo_o       = DATA_W'(ZeroWord);
    stallreq_o = 1'b0;
    valid_o    = 1'b0;
`ifdef EX_DIV_ZERO_TRAP_EN
    div_zero_o = 1'b0;
`endif
    if (rst == RstEnable) begin
      wd_o = '0;
    end else begin
      stallreq_o = div_busy;
      if (div_done) begin
        valid_o = valid_i;
        hi_o    = div_rem;
        lo_o    = div_quo;
`ifdef EX_DIV_ZERO_TRAP_EN
        whilo_o    = valid_i & !div_zero;
        div_zero_o = valid_i & div_zero;
`else
        whilo_o = valid_i;
`endif
      end else if (!div_busy && active) begin
        valid_o = 1'b1;
        wdata_o = gpr_res;
        if (is_mul) begin
          whilo_o = 1'b1;
          hi_o    = product[2*DATA_W-1:DATA_W];
          lo_o    = product[DATA_W-1:0];
        end else begin
          wreg_o = wreg_i;
        end
      end
    end
  end

endmodule
